io_port_responder: RTL and testbench

- Device-side responder for the processor's IN/OUT instructions.
- Accepts one-cycle I/O requests from the controller. An OUT word is buffered in an output FIFO, which drains to an external consumer over valid/ready.
- An IN request is served from a one-entry input holding register, which is filled by an external producer over valid/ready.
- Completion is signalled by a one-cycle ack; the controller stalls its phase sequence while busy.

---
 rtl/io_port_responder.sv | 170 +++++++++++++++++
 tb/tb_io_port_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_responder.sv
`default_nettype none
// ============================================================================
// Module   : io_port_responder
// Brief    : Device-side IN/OUT responder. OUT words go through a small FIFO
//            to a valid/ready consumer. IN words come from a one-entry holding
//            register that a valid/ready producer fills.
//            Optional macro IO_PORT_STATS_EN adds the out_total pop counter.
// Revision : 1.0  initial release
// ============================================================================
module io_port_responder #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 4,
    parameter int PTR_BITS = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [WIDTH-1:0]    cpu_wdata,
    output logic                cpu_ack,
    output logic [WIDTH-1:0]    cpu_rdata,
    output logic                cpu_busy,
    output logic [WIDTH-1:0]    dev_out_data,
    output logic                dev_out_valid,
    input  logic                dev_out_ready,
    input  logic [WIDTH-1:0]    dev_in_data,
    input  logic                dev_in_valid,
    output logic                dev_in_ready,
    output logic [PTR_BITS:0]   out_count
`ifdef IO_PORT_STATS_EN
    ,
    output logic [15:0]         out_total
`endif
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_OUT_WAIT = 2'd1,
        S_IN_WAIT  = 2'd2
    } state_t;

    localparam logic [PTR_BITS:0] c_FULL_COUNT = (PTR_BITS+1)'(DEPTH);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [WIDTH-1:0]       r_mem [DEPTH];
    logic [PTR_BITS-1:0]    r_rd_ptr;
    logic [PTR_BITS-1:0]    r_wr_ptr;
    logic [PTR_BITS:0]      r_count;
    logic [WIDTH-1:0]       r_in_buf;
    logic                   r_in_full;
    logic [WIDTH-1:0]       r_pend_data;
    logic [WIDTH-1:0]       r_rdata;
    logic                   r_ack;

    logic                   w_full;
    logic                   w_pop;
    logic                   w_push;
    logic [WIDTH-1:0]       w_push_data;
    logic                   w_take;
    logic                   w_latch_pend;
    logic                   w_load;

    // Full is judged on the registered count only: a pop in the same cycle
    // does not make room until the next edge.
    assign w_full = (r_count == c_FULL_COUNT);
    assign w_pop  = (r_count != '0) && dev_out_ready;
    assign w_load = dev_in_valid && !r_in_full;

    always_comb begin
        w_state_nxt  = r_state;
        w_push       = 1'b0;
        w_push_data  = cpu_wdata;
        w_take       = 1'b0;
        w_latch_pend = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cpu_req) begin
                    if (cpu_we) begin
                        if (!w_full) begin
                            w_push = 1'b1;
                        end else begin
                            w_latch_pend = 1'b1;
                            w_state_nxt  = S_OUT_WAIT;
                        end
                    end else if (r_in_full) begin
                        w_take = 1'b1;
                    end else begin
                        w_state_nxt = S_IN_WAIT;
                    end
                end
            end
            S_OUT_WAIT: begin
                if (!w_full) begin
                    w_push      = 1'b1;
                    w_push_data = r_pend_data;
                    w_state_nxt = S_IDLE;
                end
            end
            S_IN_WAIT: begin
                if (r_in_full) begin
                    w_take      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_in_full <= 1'b0;
            r_ack     <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_push || w_take;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Take and load are exclusive because the producer only sees
            // ready while the holding register is empty.
            if (w_take) begin
                r_rdata   <= r_in_buf;
                r_in_full <= 1'b0;
            end else if (w_load) begin
                r_in_full <= 1'b1;
            end
        end
    end

    // Data-only storage, no reset needed.
    always_ff @(posedge clock) begin
        if (!reset && w_push) r_mem[r_wr_ptr] <= w_push_data;
        if (!reset && w_load) r_in_buf <= dev_in_data;
        if (w_latch_pend)     r_pend_data <= cpu_wdata;
    end

`ifdef IO_PORT_STATS_EN
    logic [15:0] r_total;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_total <= '0;
        end else if (w_pop) begin
            r_total <= r_total + 16'd1;
        end
    end

    assign out_total = r_total;
`endif

    assign cpu_ack       = r_ack;
    assign cpu_rdata     = r_rdata;
    assign cpu_busy      = (r_state != S_IDLE);
    assign dev_out_data  = r_mem[r_rd_ptr];
    assign dev_out_valid = (r_count != '0);
    assign dev_in_ready  = !r_in_full;
    assign out_count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_io_port_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_port_responder
// Brief    : Scoreboard bench for io_port_responder: directed scenarios plus
//            random traffic against a queue-based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_io_port_responder;

    localparam int WIDTH    = 16;
    localparam int DEPTH    = 4;
    localparam int PTR_BITS = 2;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                cpu_req = 1'b0;
    logic                cpu_we = 1'b0;
    logic [WIDTH-1:0]    cpu_wdata = '0;
    logic                cpu_ack;
    logic [WIDTH-1:0]    cpu_rdata;
    logic                cpu_busy;
    logic [WIDTH-1:0]    dev_out_data;
    logic                dev_out_valid;
    logic                dev_out_ready = 1'b0;
    logic [WIDTH-1:0]    dev_in_data = '0;
    logic                dev_in_valid = 1'b0;
    logic                dev_in_ready;
    logic [PTR_BITS:0]   out_count;
`ifdef IO_PORT_STATS_EN
    logic [15:0]         out_total;
`endif

    io_port_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_BITS(PTR_BITS)) dut (
        .clock        (clock),
        .reset        (reset),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_wdata    (cpu_wdata),
        .cpu_ack      (cpu_ack),
        .cpu_rdata    (cpu_rdata),
        .cpu_busy     (cpu_busy),
        .dev_out_data (dev_out_data),
        .dev_out_valid(dev_out_valid),
        .dev_out_ready(dev_out_ready),
        .dev_in_data  (dev_in_data),
        .dev_in_valid (dev_in_valid),
        .dev_in_ready (dev_in_ready),
        .out_count    (out_count)
`ifdef IO_PORT_STATS_EN
        ,
        .out_total    (out_total)
`endif
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          stamp;
        int          count;
        bit          busy;
        bit          in_ready;
        bit          ack;
        logic [15:0] rdata;
        logic [15:0] total;
    } snap_t;

    snap_t       exp_cyc[$];
    logic [15:0] exp_pop[$];

    // Reference model: FIFO as a queue, input register as a mailbox,
    // plus a note of which request (if any) is waiting.
    localparam int M_IDLE = 0, M_OUTW = 1, M_INW = 2;
    logic [15:0] m_fifo[$];
    bit          m_mb_full = 1'b0;
    logic [15:0] m_mb_val = '0;
    int          m_wait = M_IDLE;
    logic [15:0] m_pend = '0;
    logic [15:0] m_rdata = '0;
    logic [15:0] m_total = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit    ack_n;
        snap_t s;
        ack_n = 1'b0;
        if (reset) begin
            m_fifo.delete();
            m_mb_full = 1'b0;
            m_wait    = M_IDLE;
            m_rdata   = '0;
            m_total   = '0;
        end else begin
            int  space;
            bit  do_push, do_take;
            logic [15:0] push_val;
            space    = DEPTH - m_fifo.size();
            do_push  = 1'b0;
            do_take  = 1'b0;
            push_val = cpu_wdata;
            if (m_wait == M_IDLE && cpu_req) begin
                if (cpu_we) begin
                    if (space > 0) do_push = 1'b1;
                    else begin m_pend = cpu_wdata; m_wait = M_OUTW; end
                end else begin
                    if (m_mb_full) do_take = 1'b1;
                    else m_wait = M_INW;
                end
            end else if (m_wait == M_OUTW && space > 0) begin
                do_push = 1'b1; push_val = m_pend; m_wait = M_IDLE;
            end else if (m_wait == M_INW && m_mb_full) begin
                do_take = 1'b1; m_wait = M_IDLE;
            end
            if (m_fifo.size() > 0 && dev_out_ready) begin
                exp_pop.push_back(m_fifo.pop_front());
                m_total = m_total + 16'd1;
            end
            if (do_push) m_fifo.push_back(push_val);
            if (do_take) begin
                m_rdata   = m_mb_val;
                m_mb_full = 1'b0;
            end else if (dev_in_valid && !m_mb_full) begin
                m_mb_val  = dev_in_data;
                m_mb_full = 1'b1;
            end
            ack_n = do_push || do_take;
        end
        s.stamp    = cyc + 1;
        s.count    = m_fifo.size();
        s.busy     = (m_wait != M_IDLE);
        s.in_ready = !m_mb_full;
        s.ack      = ack_n;
        s.rdata    = m_rdata;
        s.total    = m_total;
        exp_cyc.push_back(s);
    endtask

    task automatic drive(input bit rst, input bit req, input bit we, input logic [15:0] wd,
                         input bit ordy, input bit ival, input logic [15:0] idata);
        @(negedge clock);
        #1;
        reset         = rst;
        cpu_req       = req;
        cpu_we        = we;
        cpu_wdata     = wd;
        dev_out_ready = ordy;
        dev_in_valid  = ival;
        dev_in_data   = idata;
        model_step();
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 16'h0, ordy, 0, 16'h0);
    endtask

    // Monitor: samples after the driver has settled inputs, well before posedge.
    always @(negedge clock) begin
        #3;
        if (!reset && dev_out_valid && dev_out_ready) begin
            if (exp_pop.size() == 0) check("unexpected_pop", 1, 0);
            else check("pop_data", dev_out_data, exp_pop.pop_front());
        end
        while (exp_cyc.size() > 0 && exp_cyc[0].stamp < cyc) begin
            check("snapshot_stamp", exp_cyc[0].stamp, cyc);
            void'(exp_cyc.pop_front());
        end
        if (exp_cyc.size() > 0 && exp_cyc[0].stamp == cyc) begin
            snap_t s;
            s = exp_cyc.pop_front();
            check("out_count", out_count, s.count);
            check("dev_out_valid", dev_out_valid, s.count != 0);
            check("cpu_busy", cpu_busy, s.busy);
            check("dev_in_ready", dev_in_ready, s.in_ready);
            check("cpu_ack", cpu_ack, s.ack);
            check("cpu_rdata", cpu_rdata, s.rdata);
`ifdef IO_PORT_STATS_EN
            check("out_total", out_total, s.total);
`endif
        end
    end

    initial begin
        drive(1, 0, 0, 16'h0, 0, 0, 16'h0);
        drive(1, 0, 0, 16'h0, 0, 0, 16'h0);
        idle(2, 0);

        // Single OUT with consumer ready
        drive(0, 1, 1, 16'h1234, 1, 0, 16'h0);
        idle(3, 1);

        // FIFO full stall, then release
        for (int i = 1; i <= 4; i++) drive(0, 1, 1, 16'(i), 0, 0, 16'h0);
        drive(0, 1, 1, 16'h0005, 0, 0, 16'h0);
        idle(3, 0);
        idle(8, 1);

        // IN with producer idle, then one handshake
        drive(0, 1, 0, 16'h0, 0, 0, 16'h0);
        idle(5, 0);
        drive(0, 0, 0, 16'h0, 0, 1, 16'hBEEF);
        idle(3, 0);

        // IN served from an already-filled holding register
        drive(0, 0, 0, 16'h0, 0, 1, 16'h00A5);
        idle(2, 0);
        drive(0, 1, 0, 16'h0, 0, 0, 16'h0);
        idle(2, 0);

        // Reset while an OUT is waiting for space
        for (int i = 0; i < 5; i++) drive(0, 1, 1, 16'(16'hA0 + i), 0, 0, 16'h0);
        idle(2, 0);
        drive(1, 0, 0, 16'h0, 0, 0, 16'h0);
        idle(4, 1);

        // Randomised traffic in segments with varying handshake pressure
        for (int seg = 0; seg < 10; seg++) begin
            int p_rdy, p_val;
            p_rdy = $urandom_range(0, 100);
            p_val = $urandom_range(0, 100);
            for (int i = 0; i < 200; i++) begin
                drive($urandom_range(0, 299) == 0,
                      $urandom_range(0, 1) == 1,
                      $urandom_range(0, 1) == 1,
                      16'($urandom),
                      $urandom_range(0, 99) < p_rdy,
                      $urandom_range(0, 99) < p_val,
                      16'($urandom));
            end
        end
        idle(10, 1);

`ifdef IO_PORT_STATS_EN
        // Counter wrap: 0x10002 pops after reset
        drive(1, 0, 0, 16'h0, 1, 0, 16'h0);
        for (int i = 0; i < 32'h10002; i++) drive(0, 1, 1, 16'(i), 1, 0, 16'h0);
        idle(3, 1);
        @(negedge clock);
        #4;
        check("out_total_wrap", out_total, 16'h0002);
`endif

        idle(2, 0);
        @(negedge clock);
        #4;
        check("pop_queue_drained", exp_pop.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
